// File: rtl/ram_req_adapter.sv
// ram_req_adapter: valid/ready front-end for a single-port byte-maskable data
// RAM. Each accepted request issues at most one RAM access. Responses come
// back in order through a 2-entry buffer with a same-cycle bypass.
// Optional feature: define RAM_ADAPTER_ERR_CHECK_EN to reject misaligned and
// out-of-range addresses. Rejected requests make no RAM access and return an
// error response.
module ram_req_adapter #(
    parameter int MemAw = 12
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_we_i,
    input  logic [31:0]      req_addr_i,
    input  logic [3:0]       req_be_i,
    input  logic [31:0]      req_wdata_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic             mem_en_o,
    output logic [3:0]       mem_we_o,
    output logic [31:0]      mem_wdata_o,
    output logic [MemAw-1:0] mem_addr_o,
    input  logic [31:0]      mem_rdata_i
);

    logic        w_accept;
    logic        w_err;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_inf_rdata;

    // Inflight slot: carries the request accepted last cycle into the
    // cycle in which the RAM read data is available.
    logic        r_inf_valid;
    logic        r_inf_we;
    logic        r_inf_err;

    // Response buffer: 2-entry FIFO of {rdata, err}.
    logic [1:0]  r_buf_count;
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_buf_rdata [2];
    logic [1:0]  r_buf_err;

    // Ready depends on registered state only, so the upstream can never
    // form a combinational loop through this block.
    assign req_ready_o = ({1'b0, r_buf_count} + {2'b00, r_inf_valid}) < 3'd2;
    assign w_accept    = req_valid_i & req_ready_o;

`ifdef RAM_ADAPTER_ERR_CHECK_EN
    assign w_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[31:MemAw+2] != '0);
`else
    assign w_err = 1'b0;
    // Byte offset and bits above the RAM are ignored in this build.
    logic w_unused_addr;
    assign w_unused_addr = ^{req_addr_i[1:0], req_addr_i[31:MemAw+2]};
`endif

    assign mem_addr_o  = req_addr_i[MemAw+1:2];
    assign mem_wdata_o = req_wdata_i;

    // RAM strobes: only a legal accepted request touches the RAM.
    always_comb begin
        mem_en_o = w_accept & ~w_err;
        mem_we_o = (w_accept && !w_err && req_we_i) ? req_be_i : 4'h0;
    end

    // Writes and errored requests return zero data.
    assign w_inf_rdata = (r_inf_we | r_inf_err) ? 32'h0 : mem_rdata_i;

    // The inflight response is stored unless it bypasses straight to a
    // ready consumer from an empty buffer.
    assign w_pop  = (r_buf_count != 2'd0) & rsp_ready_i;
    assign w_push = r_inf_valid & ~((r_buf_count == 2'd0) & rsp_ready_i);

    // Response mux: buffered head first, then bypass of the inflight slot.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        rsp_valid_o = 1'b0;
        rsp_rdata_o = 32'h0;
        rsp_err_o   = 1'b0;
        if (r_buf_count != 2'd0) begin
            rsp_valid_o = 1'b1;
            rsp_rdata_o = r_buf_rdata[r_rd_ptr];
            rsp_err_o   = r_buf_err[r_rd_ptr];
        end else if (r_inf_valid) begin
            rsp_valid_o = 1'b1;
            rsp_rdata_o = w_inf_rdata;
            rsp_err_o   = r_inf_err;
        end
    end

    // Capture the accepted request's kind into the inflight slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: non-blocking assignments for all clocked state.
            r_inf_valid <= 1'b0;
            r_inf_we    <= 1'b0;
            r_inf_err   <= 1'b0;
        end else begin
            r_inf_valid <= w_accept;
            r_inf_we    <= req_we_i;
            r_inf_err   <= w_err;
        end
    end

    // Buffer occupancy and pointers; push and pop together hold the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_buf_count <= 2'd0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push, w_pop})
                2'b10:   r_buf_count <= r_buf_count + 2'd1;
                2'b01:   r_buf_count <= r_buf_count - 2'd1;
                default: r_buf_count <= r_buf_count;
            endcase
        end
    end

    // Buffer payload storage.
    // NOTE: payload is not reset; it is only visible while r_buf_count says
    // the entry is valid, and the count itself is reset.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf_rdata[r_wr_ptr] <= w_inf_rdata;
            r_buf_err[r_wr_ptr]   <= r_inf_err;
        end
    end

    // Ready gating makes overflow impossible; keep that visible.
    a_buf_no_overflow : assert property (
        @(posedge clk_i) disable iff (!rst_ni) r_buf_count <= 2'd2
    );

endmodule

// File: doc/ram_req_adapter.md
# ram_req_adapter

Request/response front-end that sits directly upstream of the single-port 4096x32 byte-maskable data RAM and drives its enable, write mask, data and word-address pins. It accepts byte-addressed bus requests over a valid/ready handshake, checks them, and issues at most one RAM access per cycle. It returns one response per request, in order, through a 2-entry response buffer with a same-cycle bypass, sustaining one access per cycle when the consumer is ready.

## Interface
- MemAw, 12, RAM word-address width; RAM depth is 2^MemAw words
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid and ready are both high
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  32  byte address, offset from RAM base
- req_be_i  in  4  byte enables for writes; ignored on reads
- req_wdata_i  in  32  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid and ready are both high
- rsp_rdata_o  out  32  read data; 0 for writes and errored requests
- rsp_err_o  out  1  request rejected; no RAM access made
- mem_en_o  out  1  RAM enable
- mem_we_o  out  4  RAM byte write mask
- mem_wdata_o  out  32  RAM write data
- mem_addr_o  out  MemAw  RAM word address = req_addr_i[MemAw+1:2]
- mem_rdata_i  in  32  RAM read data, valid the cycle after mem_en_o

## Operation
- Accept: req_ready_o = (buf_count + inflight) < 2; it depends only on registered state and never on req_valid_i or rsp_ready_i.
- On accept (cycle T):
  - Legal request: mem_en_o=1 combinationally in T.
  - mem_we_o = req_we_i ? req_be_i : 4'h0.
  - mem_wdata_o = req_wdata_i.
  - Write with be=0 is a legal no-op access and gets a normal response.
- Error request (see Configuration): mem_en_o=0 in T; the request still occupies an inflight slot.
- inflight register: set at the end of T. It carries the request's is_write and err flags into T+1.
- Response formation in T+1:
  - rdata = (write or err) ? 0 : mem_rdata_i.
  - err = stored err flag.
- Response buffer: 2-entry FIFO of {rdata, err}.
  - Bypass: if the buffer is empty in T+1, the response is driven directly on rsp_*; if rsp_ready_i=1 it is not stored.
  - Otherwise, or if not consumed, the response is pushed.
- The head of a non-empty buffer always has priority over the inflight response. Responses stay in order.
- Push and pop in the same cycle leave buf_count unchanged. Overflow cannot occur by construction; an assertion checks buf_count<=2.
- When no request is accepted, mem_en_o=0, mem_we_o=0, and mem_addr_o/mem_wdata_o follow the request inputs.

## Timing
- Reset values: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_en_o=0, mem_we_o=0; buf_count=0, inflight=0.
- Latency: accept at T gives rsp_valid_o at T+1 (bypass). Throughput is 1 request per cycle with rsp_ready_i held high.
- Backpressure: with rsp_ready_i=0, at most 2 requests are accepted; then req_ready_o=0 until a pop.
- rsp_valid_o, rsp_rdata_o and rsp_err_o hold stable while rsp_valid_o=1 and rsp_ready_i=0.
- Reset asserted mid-operation: buffered and inflight responses are discarded and all outputs go to reset values asynchronously. A RAM write already clocked before reset is not undone.

## Configuration
- RAM_ADAPTER_ERR_CHECK_EN defined:
  - A request errors if req_addr_i[1:0]!=0.
  - A request also errors if req_addr_i[31:MemAw+2]!=0.
  - Errored requests make no RAM access and return rsp_err_o=1, rsp_rdata_o=0.
- Not defined:
  - No checking is done; address bits [1:0] and [31:MemAw+2] are ignored.
  - Every request accesses the RAM.
  - rsp_err_o is tied to 0.

## Test plan
- Reset, then read of 0x10 with RAM word 4 preloaded to 0xDEADBEEF -> mem_en_o=1 and mem_addr_o=4 in T; rsp_valid_o=1 and rsp_rdata_o=0xDEADBEEF in T+1.
- Write 0x11223344 to 0x20 with be=4'b0101, then read 0x20 (word preset 0xAABBCCDD) -> mem_we_o=4'b0101; write response rdata=0, err=0; read returns 0xAA22CC44.
- Back-to-back reads of 0x0, 0x4, 0x8, 0xC with rsp_ready_i=1 -> req_ready_o stays 1; four responses in consecutive cycles, in order.
- rsp_ready_i=0 with requests valid every cycle -> exactly 2 accepted, then req_ready_o=0. Raise rsp_ready_i -> responses drain in order and req_ready_o returns to 1.
- ERR_CHECK_EN, reads of 0x2 and 0x4000 -> mem_en_o=0; rsp_err_o=1, rsp_rdata_o=0. Without the macro, 0x4000 reads word 0 with err=0.
- Assert rst_ni with 2 responses buffered -> rsp_valid_o=0 immediately; after release, a fresh read responds normally with no stale data.
